rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Parametrised N-channel, W-bit registered multiplexer with a valid/ready handshake on every input and on the output.
- Generalises the 4x1 select mux in two ways: width and channel count are parameters, and channel selection is either round-robin (automatic) or direct by `sel` (manual).
- One output register stage.
- Sits between several producer streams and a single shared consumer.

Parameters:
- N, 4, number of input channels (N >= 2, need not be a power of 2).
- W, 8, data width per channel.
- SW, derived (not overridable) as clog2(N), width of select and channel-id fields.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready (combinational).
- mode  in  1  0 = round-robin, 1 = manual select.
- sel  in  SW  manual-mode channel select.
- out_data  out  W  registered output data.
- out_ch  out  SW  channel index of the current out_data.
- out_valid  out  1  output valid.
- out_ready  in  1  consumer ready.

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, out_ch=0, rr_ptr=0; in_ready=0 while rst is high.
- load_en = !out_valid || out_ready. The output register is loadable when it is empty or is being drained this cycle.
- Grant in round-robin mode (mode=0): the first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, …, N-1, 0, …, rr_ptr-1 (mod N).
- Grant in manual mode (mode=1): sel, only if sel < N and in_valid[sel]=1. Otherwise there is no grant. Other channels are never granted in manual mode.
- in_ready[i] = !rst && load_en && grant exists && grant==i. At most one in_ready bit is high per cycle.
- Transfer on channel i when in_valid[i] && in_ready[i]. At the next edge: out_data<=channel i data, out_ch<=i, out_valid<=1, rr_ptr<=(i==N-1)?0:i+1. rr_ptr updates in both modes.
- load_en=1 with no grant: out_valid<=0. out_data and out_ch hold their last values.
- load_en=0 (out_valid=1, out_ready=0): out_data, out_ch, out_valid and rr_ptr all hold. No in_ready is asserted.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 transfer per cycle when out_ready is held at 1.
- No combinational path from in_data to out_data.
- Output transfer occurs on out_valid && out_ready. A new word may be loaded in the same cycle (back-to-back).
- Changes to mode or sel take effect on the next arbitration. A word already held in the output register is unaffected.
- Inputs must hold data and valid until accepted. The block does not check this.
- Wrap-around: rr_ptr advances from N-1 to 0. The scan wraps modulo N, including for non-power-of-2 N.
- Reset asserted mid-transfer: the held word is discarded and out_valid drops asynchronously. After release, arbitration restarts from channel 0.

Test Plan:
1. Reset mid-stream: rst pulses while out_valid=1 with out_data=8'h A2 -> out_valid=0 and out_data=0 without waiting for an edge, in_ready=0; after release with all valid, first grant is ch0.
2. RR fairness, N=4, W=8: in_data ch i = 8'hA0+i, all valid, out_ready=1 -> out_ch sequence 0,1,2,3,0,1; out_data A0,A1,A2,A3,A0; out_valid=1 every cycle from cycle 1.
3. Sparse RR with wrap: rr_ptr=2, in_valid=4'b1010 -> grant ch3 then ch1 then ch3; ch0 and ch2 in_ready stay 0.
4. Backpressure: out_valid=1, out_data=8'hA1, out_ready=0 for 3 cycles -> out_data and out_ch hold, in_ready=4'b0000; out_ready=1 -> next granted word appears the following cycle.
5. Manual mode: mode=1, sel=2, in_valid=4'b0101, ch2 data 8'h5C -> in_ready=4'b0100, next cycle out_data=8'h5C, out_ch=2. Then sel=1 with in_valid[1]=0 -> no grant, out_valid falls to 0 after drain even though ch0 is valid.
6. Non-power-of-2 N=3, mode=1, sel=3 -> no grant, in_ready=3'b000. Then mode=0 with all valid from rr_ptr=2 -> grants 2,0,1.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// N-channel, W-bit registered stream multiplexer with round-robin or manual
// channel selection and valid/ready handshakes on every input and the output.
module rr_mux_arbiter #(
   parameter  int N  = 4,
   parameter  int W  = 8,
   localparam int SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_valid,
   output logic [N-1:0]   in_ready,
   input  logic           mode,
   input  logic [SW-1:0]  sel,
   output logic [W-1:0]   out_data,
   output logic [SW-1:0]  out_ch,
   output logic           out_valid,
   input  logic           out_ready
);

   // Handshake: a word moves on any interface in a cycle where valid && ready
   // are both high at the rising edge; producers hold data/valid until then.

   localparam int NP = 1 << SW;

   logic [SW-1:0] rr_ptr;
   logic          load_en;
   logic          rr_ok;
   logic [SW-1:0] rr_idx;
   logic [NP-1:0] valid_ext;
   logic          grant_ok;
   logic [SW-1:0] grant_idx;
   logic [W-1:0]  grant_data;
   int            idx;

   assign load_en = !out_valid || out_ready;

   // Round-robin scan from rr_ptr; descending k so the nearest requester wins.
   always_comb begin
      rr_ok  = 1'b0;
      rr_idx = '0;
      idx    = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N) idx = idx - N;
         if (in_valid[idx]) begin
            rr_ok  = 1'b1;
            rr_idx = idx[SW-1:0];
         end
      end
   end

   // Zero-extended valid vector so out-of-range sel values read as "no request".
   always_comb begin
      valid_ext        = '0;
      valid_ext[N-1:0] = in_valid;
   end

   always_comb begin
      grant_ok  = 1'b0;
      grant_idx = '0;
      if (mode) begin
         grant_ok  = valid_ext[sel];
         grant_idx = sel;
      end else begin
         grant_ok  = rr_ok;
         grant_idx = rr_idx;
      end
   end

   always_comb begin
      in_ready   = '0;
      grant_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_idx == SW'(i)) begin
            in_ready[i] = !rst && load_en && grant_ok;
            grant_data  = in_data[i*W +: W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data  <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
         rr_ptr    <= '0;
      end else if (load_en) begin
         if (grant_ok) begin
            out_data  <= grant_data;
            out_ch    <= grant_idx;
            out_valid <= 1'b1;
            rr_ptr    <= (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: a 4-channel and a 3-channel instance.
module tb_rr_mux_arbiter;

   logic        clk;
   logic        rst;

   logic [31:0] in_data4;
   logic [3:0]  in_valid4;
   logic [3:0]  in_ready4;
   logic        mode4;
   logic [1:0]  sel4;
   logic [7:0]  out_data4;
   logic [1:0]  out_ch4;
   logic        out_valid4;
   logic        out_ready4;

   logic [23:0] in_data3;
   logic [2:0]  in_valid3;
   logic [2:0]  in_ready3;
   logic        mode3;
   logic [1:0]  sel3;
   logic [7:0]  out_data3;
   logic [1:0]  out_ch3;
   logic        out_valid3;
   logic        out_ready3;

   int n_vec;
   int n_err;

   rr_mux_arbiter #(.N(4), .W(8)) dut4 (
      .clk(clk), .rst(rst),
      .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
      .mode(mode4), .sel(sel4),
      .out_data(out_data4), .out_ch(out_ch4), .out_valid(out_valid4),
      .out_ready(out_ready4)
   );

   rr_mux_arbiter #(.N(3), .W(8)) dut3 (
      .clk(clk), .rst(rst),
      .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .mode(mode3), .sel(sel3),
      .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
      .out_ready(out_ready3)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_out4(input string tag, input logic [7:0] d, input logic [1:0] ch, input logic v);
      check({tag, ".data"}, 32'(out_data4), 32'(d));
      check({tag, ".ch"}, 32'(out_ch4), 32'(ch));
      check({tag, ".valid"}, 32'(out_valid4), 32'(v));
   endtask

   task automatic check_out3(input string tag, input logic [7:0] d, input logic [1:0] ch, input logic v);
      check({tag, ".data"}, 32'(out_data3), 32'(d));
      check({tag, ".ch"}, 32'(out_ch3), 32'(ch));
      check({tag, ".valid"}, 32'(out_valid3), 32'(v));
   endtask

   // inputs change and outputs are sampled 2 time units after each rising edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [1:0] rr_ch  [6];
      logic [7:0] rr_dat [6];
      n_vec = 0;
      n_err = 0;
      rst        = 1'b1;
      in_data4   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      in_valid4  = 4'hF;
      mode4      = 1'b0;
      sel4       = 2'd0;
      out_ready4 = 1'b0;
      in_data3   = {8'hB2, 8'hB1, 8'hB0};
      in_valid3  = 3'b000;
      mode3      = 1'b0;
      sel3       = 2'd0;
      out_ready3 = 1'b1;

      // reset state
      tick();
      tick();
      check_out4("reset", 8'h00, 2'd0, 1'b0);
      check("reset.in_ready", 32'(in_ready4), 32'h0);
      check_out3("reset3", 8'h00, 2'd0, 1'b0);

      // round-robin fairness with every channel valid
      rst        = 1'b0;
      out_ready4 = 1'b1;
      #1;
      check("rr.first_ready", 32'(in_ready4), 32'b0001);
      rr_ch  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      rr_dat = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1};
      for (int i = 0; i < 6; i++) begin
         tick();
         check_out4($sformatf("rr[%0d]", i), rr_dat[i], rr_ch[i], 1'b1);
      end

      // reset mid-stream while A2 is held
      tick();
      check_out4("pre_rst", 8'hA2, 2'd2, 1'b1);
      rst = 1'b1;
      #1;
      check_out4("async_rst", 8'h00, 2'd0, 1'b0);
      check("async_rst.in_ready", 32'(in_ready4), 32'h0);
      #1;
      rst = 1'b0;
      tick();
      check_out4("post_rst", 8'hA0, 2'd0, 1'b1);

      // backpressure while A1 is held
      tick();
      check_out4("bp.load", 8'hA1, 2'd1, 1'b1);
      out_ready4 = 1'b0;
      #1;
      check("bp.in_ready", 32'(in_ready4), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_out4($sformatf("bp.hold[%0d]", i), 8'hA1, 2'd1, 1'b1);
         check($sformatf("bp.in_ready[%0d]", i), 32'(in_ready4), 32'h0);
      end
      out_ready4 = 1'b1;
      #1;
      check("bp.release_ready", 32'(in_ready4), 32'b0100);
      tick();
      check_out4("bp.next", 8'hA2, 2'd2, 1'b1);

      // walk rr_ptr from 3 round to 2
      tick();
      check_out4("walk0", 8'hA3, 2'd3, 1'b1);
      tick();
      check_out4("walk1", 8'hA0, 2'd0, 1'b1);
      tick();
      check_out4("walk2", 8'hA1, 2'd1, 1'b1);

      // sparse requests wrap past the top channel
      in_valid4 = 4'b1010;
      #1;
      check("sparse.ready0", 32'(in_ready4), 32'b1000);
      tick();
      check_out4("sparse0", 8'hA3, 2'd3, 1'b1);
      check("sparse.ready1", 32'(in_ready4), 32'b0010);
      tick();
      check_out4("sparse1", 8'hA1, 2'd1, 1'b1);
      check("sparse.ready2", 32'(in_ready4), 32'b1000);
      tick();
      check_out4("sparse2", 8'hA3, 2'd3, 1'b1);

      // manual select
      mode4     = 1'b1;
      sel4      = 2'd2;
      in_valid4 = 4'b0101;
      in_data4  = {8'hA3, 8'h5C, 8'hA1, 8'hA0};
      #1;
      check("man.ready", 32'(in_ready4), 32'b0100);
      tick();
      check_out4("man.load", 8'h5C, 2'd2, 1'b1);
      sel4 = 2'd1;
      #1;
      check("man.nogrant_ready", 32'(in_ready4), 32'h0);
      tick();
      check_out4("man.drain", 8'h5C, 2'd2, 1'b0);

      // non-power-of-2 channel count: out-of-range select, then rr wrap
      mode3     = 1'b1;
      sel3      = 2'd3;
      in_valid3 = 3'b111;
      #1;
      check("n3.sel3_ready", 32'(in_ready3), 32'h0);
      tick();
      check("n3.sel3_valid", 32'(out_valid3), 32'h0);
      sel3 = 2'd1;
      #1;
      check("n3.sel1_ready", 32'(in_ready3), 32'b010);
      tick();
      check_out3("n3.sel1", 8'hB1, 2'd1, 1'b1);
      mode3 = 1'b0;
      #1;
      check("n3.rr_ready", 32'(in_ready3), 32'b100);
      tick();
      check_out3("n3.rr0", 8'hB2, 2'd2, 1'b1);
      tick();
      check_out3("n3.rr1", 8'hB0, 2'd0, 1'b1);
      tick();
      check_out3("n3.rr2", 8'hB1, 2'd1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
